// File: rtl/counter_checker_pkg.sv
// rtl/counter_checker_pkg.sv - shared types and reference next-count function for the counter checker
// Purpose : FSM state type and the up/down counter next-value rule used as the shadow model.
// Contents: chk_state_e, cnt_word_t, counter_next().
package counter_checker_pkg;

    // Widest counter the model supports; callers zero-extend in and truncate out,
    // which keeps the +1/-1 arithmetic correct modulo 2^WIDTH for any WIDTH <= CNT_MAX_W.
    localparam int CNT_MAX_W = 32;

    typedef logic [CNT_MAX_W-1:0] cnt_word_t;

    typedef enum logic {
        SYNC  = 1'b0,
        TRACK = 1'b1
    } chk_state_e;

    function automatic cnt_word_t counter_next(
        input cnt_word_t exp_val,
        input logic      rst_n,
        input logic      load_n,
        input logic      ce,
        input logic      up_down,
        input cnt_word_t data_load
    );
        cnt_word_t nxt;
        nxt = exp_val;
        if (!rst_n) begin
            nxt = '0;
        end else if (!load_n) begin
            nxt = data_load;
        end else if (ce) begin
            nxt = up_down ? exp_val + cnt_word_t'(1) : exp_val - cnt_word_t'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/counter_checker_if.sv
// rtl/counter_checker_if.sv - up/down counter control and status signal bundle
// Purpose : signals shared by the counter, its stimulus driver and the checker.
// Modports: master drives every signal (driver/counter side); slave observes every signal (checker).
interface counter_checker_if #(
    parameter int WIDTH = 4
);
    logic             rst_n;
    logic             load_n;
    logic             ce;
    logic             up_down;
    logic [WIDTH-1:0] data_load;
    logic [WIDTH-1:0] count_out;
    logic             max_count;
    logic             zero;

    modport master (
        output rst_n, load_n, ce, up_down, data_load, count_out, max_count, zero
    );

    modport slave (
        input rst_n, load_n, ce, up_down, data_load, count_out, max_count, zero
    );
endinterface

// File: rtl/counter_checker_sat_counter.sv
// rtl/counter_checker_sat_counter.sv - saturating statistics counter
// Purpose : counts inc pulses, sticks at all ones, clr has priority over inc.
// Ports   : clk, rst (async, active high), inc, clr, cnt (ERR_W bits).
module sat_counter #(
    parameter int ERR_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [ERR_W-1:0] cnt
);
    logic [ERR_W-1:0] cnt_q;
    logic [ERR_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {ERR_W{1'b1}})) begin
            cnt_d = cnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/counter_checker.sv
// rtl/counter_checker.sv - passive scoreboard for the up/down counter
// Purpose : shadows the counter from its sampled controls, compares its outputs one edge later,
//           flags mismatches and keeps saturating error/compare/wrap statistics.
// Ports   : clk, rst (async, active high), clear (sync stats clear), bus (observed counter signals),
//           synced, mismatch, fail, err_cnt, chk_cnt, wrap_up_cnt, wrap_dn_cnt.
module counter_checker
    import counter_checker_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int ERR_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    counter_checker_if.slave bus,
    output logic             synced,
    output logic             mismatch,
    output logic             fail,
    output logic [ERR_W-1:0] err_cnt,
    output logic [ERR_W-1:0] chk_cnt,
    output logic [ERR_W-1:0] wrap_up_cnt,
    output logic [ERR_W-1:0] wrap_dn_cnt
);
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    chk_state_e       state_q, state_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic             mismatch_q, mismatch_d;
    logic             fail_q, fail_d;

    logic             init_ev;
    logic             cmp_en;
    logic             diff;
    logic             err_inc;
    logic             counting;
    logic             wrap_up;
    logic             wrap_dn;

    // A reset or load is the only event that makes the counter value knowable.
    assign init_ev = !bus.rst_n || !bus.load_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SYNC:    if (init_ev) state_d = TRACK;
            TRACK:   state_d = TRACK;
            default: state_d = SYNC;
        endcase
    end

    always_comb begin
        synced = 1'b0;
        cmp_en = 1'b0;
        if (state_q == TRACK) begin
            synced = 1'b1;
            cmp_en = 1'b1;
        end
    end

    // exp_q holds what the counter should show now; it is checked before being advanced.
    assign diff = (bus.count_out != exp_q)
               || (bus.max_count != (exp_q == ALL_ONES))
               || (bus.zero      != (exp_q == '0));
    assign err_inc = cmp_en && diff;

    assign counting = cmp_en && bus.rst_n && bus.load_n && bus.ce;
    assign wrap_up  = counting &&  bus.up_down && (exp_q == ALL_ONES);
    assign wrap_dn  = counting && !bus.up_down && (exp_q == '0);

    always_comb begin
        exp_d = exp_q;
        if (cmp_en || init_ev) begin
            exp_d = WIDTH'(counter_next(CNT_MAX_W'(exp_q), bus.rst_n, bus.load_n,
                                        bus.ce, bus.up_down, CNT_MAX_W'(bus.data_load)));
        end
        // mismatch reports the compare regardless of clear; fail obeys clear.
        mismatch_d = err_inc;
        fail_d     = clear ? 1'b0 : (fail_q || err_inc);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q      <= '0;
            mismatch_q <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            exp_q      <= exp_d;
            mismatch_q <= mismatch_d;
            fail_q     <= fail_d;
        end
    end

    assign mismatch = mismatch_q;
    assign fail     = fail_q;

    sat_counter #(.ERR_W(ERR_W)) u_err_cnt (
        .clk(clk), .rst(rst), .inc(err_inc),  .clr(clear), .cnt(err_cnt)
    );
    sat_counter #(.ERR_W(ERR_W)) u_chk_cnt (
        .clk(clk), .rst(rst), .inc(cmp_en),   .clr(clear), .cnt(chk_cnt)
    );
    sat_counter #(.ERR_W(ERR_W)) u_wrap_up_cnt (
        .clk(clk), .rst(rst), .inc(wrap_up),  .clr(clear), .cnt(wrap_up_cnt)
    );
    sat_counter #(.ERR_W(ERR_W)) u_wrap_dn_cnt (
        .clk(clk), .rst(rst), .inc(wrap_dn),  .clr(clear), .cnt(wrap_dn_cnt)
    );
endmodule

// File: tb/tb_counter_checker.sv
// tb/tb_counter_checker.sv - scoreboard bench for counter_checker with a behavioural counter and fault injection
module tb_counter_checker;
    localparam int W    = 4;
    localparam int MOD  = 16;
    localparam int MAXV = 15;

    logic clk;
    logic rst;
    logic clear;

    counter_checker_if #(.WIDTH(W)) cif ();

    logic        synced, mismatch, fail;
    logic [15:0] err_cnt, chk_cnt, wrap_up_cnt, wrap_dn_cnt;
    logic        synced2, mismatch2, fail2;
    logic [1:0]  err_cnt2, chk_cnt2, wrap_up_cnt2, wrap_dn_cnt2;

    counter_checker #(.WIDTH(W), .ERR_W(16)) dut (
        .clk(clk), .rst(rst), .clear(clear), .bus(cif),
        .synced(synced), .mismatch(mismatch), .fail(fail),
        .err_cnt(err_cnt), .chk_cnt(chk_cnt),
        .wrap_up_cnt(wrap_up_cnt), .wrap_dn_cnt(wrap_dn_cnt)
    );

    counter_checker #(.WIDTH(W), .ERR_W(2)) dut_sat (
        .clk(clk), .rst(rst), .clear(clear), .bus(cif),
        .synced(synced2), .mismatch(mismatch2), .fail(fail2),
        .err_cnt(err_cnt2), .chk_cnt(chk_cnt2),
        .wrap_up_cnt(wrap_up_cnt2), .wrap_dn_cnt(wrap_dn_cnt2)
    );

    typedef struct {
        bit synced;
        bit mism;
        bit fail;
        int err;
        int err2;
        int chk;
        int chk2;
        int wu;
        int wd;
    } exp_t;

    exp_t exp_q[$];

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state: what the checker should believe and report.
    bit m_known  = 0;
    int m_exp    = 0;
    bit m_fail   = 0;
    int m_err    = 0;
    int m_err2   = 0;
    int m_chk    = 0;
    int m_chk2   = 0;
    int m_wu     = 0;
    int m_wd     = 0;
    // The observed counter itself (fault-free value).
    int ctr      = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    function automatic int sat_inc(input int v, input int max);
        return (v < max) ? v + 1 : v;
    endfunction

    // Drives one cycle's inputs at the falling edge and records what the
    // checkers must show after the following rising edge.
    task automatic step(input bit r, input bit rn, input bit ln, input bit c,
                        input bit ud, input int dl, input bit fault, input bit clr);
        int   co;
        bit   d;
        bit   mism;
        exp_t e;
        @(negedge clk);
        co = fault ? (ctr + 1) % MOD : ctr;
        rst           = r;
        clear         = clr;
        cif.rst_n     = rn;
        cif.load_n    = ln;
        cif.ce        = c;
        cif.up_down   = ud;
        cif.data_load = dl[W-1:0];
        cif.count_out = co[W-1:0];
        cif.max_count = (ctr == MAXV);
        cif.zero      = (ctr == 0);

        mism = 0;
        if (r) begin
            m_known = 0; m_exp = 0; m_fail = 0;
            m_err = 0; m_err2 = 0; m_chk = 0; m_chk2 = 0; m_wu = 0; m_wd = 0;
        end else begin
            if (m_known) begin
                d = (co != m_exp) || ((ctr == MAXV) != (m_exp == MAXV))
                                  || ((ctr == 0) != (m_exp == 0));
                mism   = d;
                m_chk  = sat_inc(m_chk, 65535);
                m_chk2 = sat_inc(m_chk2, 3);
                if (d) begin
                    m_err  = sat_inc(m_err, 65535);
                    m_err2 = sat_inc(m_err2, 3);
                    m_fail = 1;
                end
                if (rn && ln && c) begin
                    if (ud && m_exp == MAXV) m_wu = sat_inc(m_wu, 65535);
                    if (!ud && m_exp == 0)   m_wd = sat_inc(m_wd, 65535);
                end
            end
            if (clr) begin
                m_err = 0; m_err2 = 0; m_chk = 0; m_chk2 = 0; m_wu = 0; m_wd = 0; m_fail = 0;
            end
            if (!rn) begin
                m_exp = 0; m_known = 1;
            end else if (!ln) begin
                m_exp = dl % MOD; m_known = 1;
            end else if (m_known && c) begin
                m_exp = ud ? (m_exp + 1) % MOD : (m_exp + MOD - 1) % MOD;
            end
        end

        e.synced = m_known; e.mism = mism; e.fail = m_fail;
        e.err = m_err; e.err2 = m_err2; e.chk = m_chk; e.chk2 = m_chk2;
        e.wu = m_wu; e.wd = m_wd;
        exp_q.push_back(e);

        if (!rn)      ctr = 0;
        else if (!ln) ctr = dl % MOD;
        else if (c)   ctr = ud ? (ctr + 1) % MOD : (ctr + MOD - 1) % MOD;
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: one expected record is retired after every rising edge that has one.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("synced",      synced,      e.synced);
                check("mismatch",    mismatch,    e.mism);
                check("fail",        fail,        e.fail);
                check("err_cnt",     err_cnt,     e.err);
                check("chk_cnt",     chk_cnt,     e.chk);
                check("wrap_up_cnt", wrap_up_cnt, e.wu);
                check("wrap_dn_cnt", wrap_dn_cnt, e.wd);
                check("err_cnt_w2",  err_cnt2,    e.err2);
                check("chk_cnt_w2",  chk_cnt2,    e.chk2);
                check("mismatch_w2", mismatch2,   e.mism);
            end
        end
    end

    initial begin
        rst = 1'b1; clear = 1'b0;
        cif.rst_n = 1'b1; cif.load_n = 1'b1; cif.ce = 1'b0; cif.up_down = 1'b0;
        cif.data_load = '0; cif.count_out = '0; cif.max_count = 1'b0; cif.zero = 1'b1;

        @(posedge clk);
        #1;
        check("reset_synced",   synced,   0);
        check("reset_mismatch", mismatch, 0);
        check("reset_fail",     fail,     0);
        check("reset_err_cnt",  err_cnt,  0);
        check("reset_chk_cnt",  chk_cnt,  0);

        // rst for two cycles, then counter reset initialises the model.
        step(1, 1, 1, 0, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        settle();
        check("init_synced",  synced,  1);
        check("init_chk_cnt", chk_cnt, 0);
        step(0, 1, 1, 0, 0, 0, 0, 0);
        settle();
        check("first_chk_cnt", chk_cnt, 1);
        check("first_fail",    fail,    0);

        // Load E, count up through the all-ones boundary.
        step(0, 1, 0, 0, 0, 14, 0, 0);
        step(0, 1, 1, 1, 1, 0, 0, 0);
        step(0, 1, 1, 1, 1, 0, 0, 0);
        step(0, 1, 1, 1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0, 0);
        settle();
        check("up_wrap_cnt", wrap_up_cnt, 1);
        check("up_err_cnt",  err_cnt,     0);

        // Load 0, count down once to F, then compare F with max_count.
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0, 0);
        settle();
        check("dn_wrap_cnt", wrap_dn_cnt, 1);
        check("dn_err_cnt",  err_cnt,     0);

        // Single-cycle fault: mismatch follows the faulted edge.
        step(0, 1, 1, 0, 0, 0, 1, 0);
        settle();
        check("fault_mismatch", mismatch, 1);
        check("fault_fail",     fail,     1);
        check("fault_err_cnt",  err_cnt,  1);
        step(0, 1, 1, 0, 0, 0, 0, 0);
        settle();
        check("fault_pulse_end", mismatch, 0);

        // Fault with clear in the same cycle.
        step(0, 1, 1, 0, 0, 0, 1, 1);
        settle();
        check("clr_mismatch", mismatch, 1);
        check("clr_err_cnt",  err_cnt,  0);
        check("clr_fail",     fail,     0);

        // Five consecutive faults saturate the 2-bit error counter.
        for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0, 0, 1, 0);
        settle();
        check("sat_err_cnt_w2", err_cnt2, 3);
        check("sat_err_cnt",    err_cnt,  5);

        // Checker reset mid-run, then randomized traffic.
        step(1, 1, 1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 15) != 0),
                 ($urandom_range(0, 7) != 0),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 15)),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 31) == 0));
        end
        step(0, 1, 1, 0, 0, 0, 0, 0);

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/counter_checker.md
# counter_checker

Synthesizable scoreboard that sits beside the up/down counter on the same `counter_if` signals. It passively samples the counter's control inputs and its `count_out`/`max_count`/`zero` outputs each clock. It keeps a shadow count, flags every mismatch, and accumulates error and wrap statistics. It is the reading end of the counter interface, complementing the stimulus driver, so self-checking runs on emulation/FPGA without a software model.

## Interface
- `WIDTH`, 4, counter data width; must match the counter.
- `ERR_W`, 16, width of the saturating statistics counters.
- `clk` in 1: sampling clock, same clock as the counter.
- `rst` in 1: asynchronous, active-high checker reset.
- `clear` in 1: synchronous clear of the statistics and `fail`; does not affect the shadow count.
- `rst_n` in 1: counter reset as driven on the interface (observed only).
- `load_n` in 1: counter load strobe, active low (observed).
- `ce` in 1: counter count enable (observed).
- `up_down` in 1: 1 means count up, 0 means count down (observed).
- `data_load` in WIDTH: counter load value (observed).
- `count_out` in WIDTH: counter output (observed).
- `max_count` in 1: counter all-ones flag (observed).
- `zero` in 1: counter all-zeros flag (observed).
- `synced` out 1: the shadow count is valid.
- `mismatch` out 1: one-cycle pulse when the checked outputs disagree with the model.
- `fail` out 1: sticky; set on any mismatch.
- `err_cnt` out ERR_W: number of mismatches, saturating.
- `chk_cnt` out ERR_W: number of compares performed, saturating.
- `wrap_up_cnt` out ERR_W: number of up-wraps (all-ones to 0), saturating.
- `wrap_dn_cnt` out ERR_W: number of down-wraps (0 to all-ones), saturating.

## Operation
- Counter model, evaluated on the inputs sampled at each posedge, in priority order:
  - `rst_n` = 0 gives 0.
  - else `load_n` = 0 gives `data_load`; `ce` is ignored.
  - else `ce` = 1 with `up_down` = 1 gives exp+1.
  - else `ce` = 1 with `up_down` = 0 gives exp-1.
  - else hold.
  - Arithmetic is modulo 2^WIDTH.
- States:
  - SYNC: the shadow count is unknown. No compares are made.
  - TRACK: compares every cycle.
  - Transitions:
    - SYNC to TRACK at the first edge where `rst_n` = 0 or `load_n` = 0; the shadow count is initialised by that edge.
    - TRACK to SYNC only on `rst`.
- Compare, in TRACK, at each edge after the shadow count was initialised:
  - `count_out` == exp.
  - `max_count` == (exp == all ones).
  - `zero` == (exp == 0).
  - Any inequality raises `mismatch`, sets `fail` and increments `err_cnt`.
  - `chk_cnt` increments on every compare.
- Wraps, counted from the model:
  - up-wrap: exp == all ones, counting up with `ce`, no reset or load.
  - down-wrap: exp == 0, counting down, same conditions.
- Statistics saturate at 2^ERR_W-1.
- `clear` zeroes `err_cnt`, `chk_cnt`, `wrap_up_cnt`, `wrap_dn_cnt` and `fail`.
  - `clear` wins over any same-cycle increment.
  - `mismatch` still pulses in a cycle where `clear` is high.
- Resync after a mismatch: the model does not resync to `count_out`. It keeps its own value, so a stuck counter keeps producing mismatches.

## Timing
- Reset values: state SYNC; `synced`, `mismatch` and `fail` = 0; all counters and the shadow count = 0.
- Edge k: sample the inputs and update exp to the value the counter should hold after edge k.
- Edge k+1: compare the sampled outputs against exp.
  - The registered `mismatch`, `fail` and count updates are visible after edge k+1.
  - Latency: 1 cycle from a wrong value being present at an edge to `mismatch` being high.
- `synced` rises after the edge that initialises the model; the first compare happens at the following edge.
- `rst` mid-run: immediate return to SYNC; all statistics are lost.
- Counter `rst_n` low in TRACK is a legal event: the model goes to 0 and compares continue.
- All observed inputs are treated as synchronous to `clk`. The counter's asynchronous reset is seen only at sampling edges.

## Structure
- Package `counter_checker_pkg`:
  - state enum `chk_state_e` {SYNC, TRACK};
  - function `counter_next(exp, rst_n, load_n, ce, up_down, data_load)` returning the model's next value.
  - The package is parameterised through a WIDTH-generic function or a class-free localparam default.
- Sub-module `sat_counter` (ERR_W, inc, clr), instantiated four times for the statistics.

## Test plan
- `rst` for 2 cycles, then `rst_n` = 0 for 1 edge -> `synced` = 1 after the next edge; `fail` = 0; `chk_cnt` increments from 0.
- WIDTH = 4, load 4'hE, then ce = 1 and up_down = 1 for 3 edges with a correct counter -> values F, 0, 1; `wrap_up_cnt` = 1; `err_cnt` = 0.
- Load 0, then count down 1 edge -> `wrap_dn_cnt` = 1; `max_count` checked high at F.
- Force `count_out` one higher than expected for 1 cycle -> `mismatch` pulses once, one cycle later; `fail` = 1; `err_cnt` = 1.
- Assert `clear` in the same cycle as a mismatch -> `mismatch` = 1; `err_cnt` = 0 and `fail` = 0 afterwards.
- ERR_W = 2, 5 consecutive mismatches -> `err_cnt` holds at 3.
